mcpu_mem_arbiter: RTL and testbench
===================================

Name: mcpu_mem_arbiter

Overview:
- Arbiter that shares the MCPU's single-port 256-word program/data RAM between two requesters.
- Requester 1 is the CPU (instruction fetch, load, store). Requester 2 is an external host port (program loader / result monitor, e.g. reading the hailstone value at address 20).
- It sits between the requesters and the RAM, serialises their accesses, and guarantees the host cannot be starved by a CPU that requests every cycle.

Parameters:
WORD_SIZE, 16, RAM data width (4-bit opcode + three 4-bit operands)
ADDR_SIZE, 8, RAM address width (256 words)
HOST_MAX_WAIT, 4, number of consecutive lost arbitrations after which the host wins over the CPU

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
cpu_req  in  1  CPU access request; held with fields stable until cpu_gnt seen
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_SIZE  CPU address
cpu_wdata  in  WORD_SIZE  CPU write data
cpu_gnt  out  1  one-cycle grant pulse
cpu_rvalid  out  1  one-cycle read-data-valid pulse
cpu_rdata  out  WORD_SIZE  CPU read data, held until next CPU read completes
host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_SIZE/WORD_SIZE  host request, same rules as CPU
host_gnt, host_rvalid, host_rdata  out  1/1/WORD_SIZE  host grant, read valid, read data
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_SIZE  RAM address
ram_wdata  out  WORD_SIZE  RAM write data
ram_rdata  in  WORD_SIZE  RAM read data, valid the cycle after ram_en=1, ram_we=0
host_wait  out  3  current host starvation count (status)

Behaviour:
- Reset (reset=0, asynchronous):
  - Every output is 0.
  - State = IDLE, wait count = 0.
  - A read in flight is dropped: no rvalid follows.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - Requests are sampled at the clock edge.
  - No request: stay in IDLE.
  - Any request: latch winner, we, addr and wdata, then go to ISSUE.
- Winner selection:
  - Only CPU requesting: CPU wins.
  - Only host requesting: host wins.
  - Both requesting: CPU wins unless host_wait >= HOST_MAX_WAIT, in which case the host wins.
- Wait counter:
  - Increments (saturating at 7) when both request and the CPU wins.
  - Clears when the host is granted or host_req=0 is sampled in IDLE.
- ISSUE (exactly one cycle):
  - ram_en=1; ram_we, ram_addr and ram_wdata come from the latched request.
  - The winner's gnt=1.
  - Next state is WAIT_RD for a read, IDLE for a write.
- WAIT_RD (one cycle):
  - ram_rdata is captured into the winner's rdata register.
  - Next state is IDLE.
  - During the following cycle the winner's rvalid=1 and rdata holds the new value.
- Requests are not sampled in ISSUE or WAIT_RD. A requester that drops req the cycle after gnt is therefore never double-granted.
- Latency, counted from the edge that samples req:
  - gnt and ram_en in cycle +1.
  - Read rvalid in cycle +3.
  - Writes occupy 2 cycles, reads 3.
- Outside ISSUE: ram_en=0 and ram_we=0; ram_addr and ram_wdata hold their last value.
- rdata of the non-winning requester never changes.
- Read and write to the same address back-to-back: the read returns the newly written data, because the write completes before the read issues.
- Address wrap: none. ADDR_SIZE covers the full RAM.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0, host_wait=0; release -> FSM idles with no ram_en.
- CPU write then read: cpu write addr 0x14, data 0x0001; then read 0x14 -> cpu_gnt/ram_en one cycle after each sample; cpu_rvalid 3 cycles after read sample with cpu_rdata=0x0001; host_rdata unchanged.
- Host-only read: preload RAM[5]=0xA123, host read 5 -> host_gnt at +1, host_rvalid at +3 with 0xA123; cpu_gnt stays 0.
- Contention: both requesters re-request immediately after each gnt, writes only, HOST_MAX_WAIT=4 -> grant order C,C,C,C,H,C,C,C,C,H; host_wait counts 1..4 then 0.
- Host drops request: host_req drops while host_wait=2 -> host_wait clears to 0 on the next IDLE sample.
- Reset mid-read: assert reset during WAIT_RD -> no rvalid pulse, ram_en=0 immediately; after release, a new CPU read completes normally.

Source files
------------

// File: rtl/mcpu_mem_arbiter.sv
// Shares the MCPU single-port program/data RAM between the CPU and an external host port.
// Fixed priority to the CPU, with the host forced through after HOST_MAX_WAIT lost arbitrations.
module mcpu_mem_arbiter #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDR_SIZE     = 8,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [WORD_SIZE-1:0] host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [WORD_SIZE-1:0] host_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  input  logic [WORD_SIZE-1:0] ram_rdata,
  output logic [2:0]           host_wait
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  localparam logic [2:0] MAX_WAIT = 3'(HOST_MAX_WAIT);

  state_t                 state_q, state_d;
  logic                   win_host_q, win_host_d;
  logic                   cpu_gnt_q, cpu_gnt_d;
  logic                   host_gnt_q, host_gnt_d;
  logic                   cpu_rvalid_q, cpu_rvalid_d;
  logic                   host_rvalid_q, host_rvalid_d;
  logic [WORD_SIZE-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [WORD_SIZE-1:0]   host_rdata_q, host_rdata_d;
  logic                   ram_en_q, ram_en_d;
  logic                   ram_we_q, ram_we_d;
  logic [ADDR_SIZE-1:0]   ram_addr_q, ram_addr_d;
  logic [WORD_SIZE-1:0]   ram_wdata_q, ram_wdata_d;
  logic [2:0]             host_wait_q, host_wait_d;
  logic                   pick_host;

  always_comb begin
    state_d       = state_q;
    win_host_d    = win_host_q;
    cpu_gnt_d     = 1'b0;
    host_gnt_d    = 1'b0;
    cpu_rvalid_d  = 1'b0;
    host_rvalid_d = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    host_rdata_d  = host_rdata_q;
    ram_en_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    host_wait_d   = host_wait_q;
    pick_host     = host_req && (!cpu_req || (host_wait_q >= MAX_WAIT));

    case (state_q)
      IDLE: begin
        // Counter only survives a sample where the host asked and lost.
        if (host_req && cpu_req && !pick_host) begin
          host_wait_d = (host_wait_q == 3'd7) ? 3'd7 : host_wait_q + 3'd1;
        end else begin
          host_wait_d = 3'd0;
        end
        if (cpu_req || host_req) begin
          state_d     = ISSUE;
          win_host_d  = pick_host;
          cpu_gnt_d   = !pick_host;
          host_gnt_d  = pick_host;
          ram_en_d    = 1'b1;
          ram_we_d    = pick_host ? host_we    : cpu_we;
          ram_addr_d  = pick_host ? host_addr  : cpu_addr;
          ram_wdata_d = pick_host ? host_wdata : cpu_wdata;
        end
      end
      ISSUE: begin
        // ram_we_q still holds the latched direction of the access in flight.
        state_d = ram_we_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        state_d = IDLE;
        if (win_host_q) begin
          host_rdata_d  = ram_rdata;
          host_rvalid_d = 1'b1;
        end else begin
          cpu_rdata_d  = ram_rdata;
          cpu_rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      win_host_q    <= 1'b0;
      cpu_gnt_q     <= 1'b0;
      host_gnt_q    <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      cpu_rdata_q   <= '0;
      host_rdata_q  <= '0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      host_wait_q   <= 3'd0;
    end else begin
      state_q       <= state_d;
      win_host_q    <= win_host_d;
      cpu_gnt_q     <= cpu_gnt_d;
      host_gnt_q    <= host_gnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      host_rdata_q  <= host_rdata_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      host_wait_q   <= host_wait_d;
    end
  end

  assign cpu_gnt     = cpu_gnt_q;
  assign host_gnt    = host_gnt_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign host_rdata  = host_rdata_q;
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign host_wait   = host_wait_q;

endmodule

// File: tb/tb_mcpu_mem_arbiter.sv
// Directed bench for mcpu_mem_arbiter with a behavioural single-port RAM attached.
module tb_mcpu_mem_arbiter;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        host_req, host_we;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_gnt, host_rvalid;
  logic [15:0] host_rdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [2:0]  host_wait;

  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcpu_mem_arbiter #(.WORD_SIZE(16), .ADDR_SIZE(8), .HOST_MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .host_wait(host_wait)
  );

  // Single-port RAM: read data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        cr, cw;
    logic [7:0]  ca;
    logic [15:0] cd;
    logic        hr, hw;
    logic [7:0]  ha;
    logic [15:0] hd;
    logic        cg, hg, ren, rwe;
    logic [7:0]  ra;
    logic [15:0] rd;
    logic        crv;
    logic [15:0] crd;
    logic        hrv;
    logic [15:0] hrd;
    logic [2:0]  hwt;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 16'h0000;
  endtask

  task automatic wait_gnt(input string nm, output logic got);
    got = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (cpu_gnt || host_gnt) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=no_gnt required=gnt", nm);
    end
  endtask

  initial begin
    logic       got;
    logic       any_out;
    logic [9:0] host_order;
    int         lat;

    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    ram_rdata = 16'h0000;

    // Reset held with random stimulus
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = 8'($urandom); cpu_wdata = 16'($urandom);
      host_req = 1'($urandom); host_we = 1'($urandom); host_addr = 8'($urandom); host_wdata = 16'($urandom);
      tick();
      any_out = |{cpu_gnt, cpu_rvalid, cpu_rdata, host_gnt, host_rvalid, host_rdata,
                  ram_en, ram_we, ram_addr, ram_wdata, host_wait};
      chk($sformatf("reset_outs_zero c%0d", c), 32'(any_out), 32'd0);
    end
    chk("reset host_wait", 32'(host_wait), 32'd0);
    idle_inputs();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("post_reset ram_en c%0d", c), 32'(ram_en), 32'd0);
    end

    // Vector table: inputs applied before the edge, outputs checked after it
    vt[0]  = '{I,I,8'h14,16'h0001, O,O,8'h00,16'h0000, I,O,I,I,8'h14,16'h0001, O,16'h0000, O,16'h0000, 3'd0};
    vt[1]  = '{O,O,8'h00,16'h0000, O,O,8'h00,16'h0000, O,O,O,O,8'h14,16'h0001, O,16'h0000, O,16'h0000, 3'd0};
    vt[2]  = '{I,O,8'h14,16'h0000, O,O,8'h00,16'h0000, I,O,I,O,8'h14,16'h0000, O,16'h0000, O,16'h0000, 3'd0};
    vt[3]  = '{O,O,8'h00,16'h0000, O,O,8'h00,16'h0000, O,O,O,O,8'h14,16'h0000, O,16'h0000, O,16'h0000, 3'd0};
    vt[4]  = '{O,O,8'h00,16'h0000, O,O,8'h00,16'h0000, O,O,O,O,8'h14,16'h0000, I,16'h0001, O,16'h0000, 3'd0};
    vt[5]  = '{O,O,8'h00,16'h0000, O,O,8'h00,16'h0000, O,O,O,O,8'h14,16'h0000, O,16'h0001, O,16'h0000, 3'd0};
    vt[6]  = '{O,O,8'h00,16'h0000, I,I,8'h05,16'hA123, O,I,I,I,8'h05,16'hA123, O,16'h0001, O,16'h0000, 3'd0};
    vt[7]  = '{O,O,8'h00,16'h0000, O,O,8'h00,16'h0000, O,O,O,O,8'h05,16'hA123, O,16'h0001, O,16'h0000, 3'd0};
    vt[8]  = '{O,O,8'h00,16'h0000, I,O,8'h05,16'h5555, O,I,I,O,8'h05,16'h5555, O,16'h0001, O,16'h0000, 3'd0};
    vt[9]  = '{O,O,8'h00,16'h0000, O,O,8'h00,16'h0000, O,O,O,O,8'h05,16'h5555, O,16'h0001, O,16'h0000, 3'd0};
    vt[10] = '{O,O,8'h00,16'h0000, O,O,8'h00,16'h0000, O,O,O,O,8'h05,16'h5555, O,16'h0001, I,16'hA123, 3'd0};
    vt[11] = '{O,O,8'h00,16'h0000, O,O,8'h00,16'h0000, O,O,O,O,8'h05,16'h5555, O,16'h0001, O,16'hA123, 3'd0};

    for (int i = 0; i < 12; i++) begin
      cpu_req = vt[i].cr; cpu_we = vt[i].cw; cpu_addr = vt[i].ca; cpu_wdata = vt[i].cd;
      host_req = vt[i].hr; host_we = vt[i].hw; host_addr = vt[i].ha; host_wdata = vt[i].hd;
      tick();
      chk($sformatf("v%0d cpu_gnt", i),     32'(cpu_gnt),     32'(vt[i].cg));
      chk($sformatf("v%0d host_gnt", i),    32'(host_gnt),    32'(vt[i].hg));
      chk($sformatf("v%0d ram_en", i),      32'(ram_en),      32'(vt[i].ren));
      chk($sformatf("v%0d ram_we", i),      32'(ram_we),      32'(vt[i].rwe));
      chk($sformatf("v%0d ram_addr", i),    32'(ram_addr),    32'(vt[i].ra));
      chk($sformatf("v%0d ram_wdata", i),   32'(ram_wdata),   32'(vt[i].rd));
      chk($sformatf("v%0d cpu_rvalid", i),  32'(cpu_rvalid),  32'(vt[i].crv));
      chk($sformatf("v%0d cpu_rdata", i),   32'(cpu_rdata),   32'(vt[i].crd));
      chk($sformatf("v%0d host_rvalid", i), 32'(host_rvalid), 32'(vt[i].hrv));
      chk($sformatf("v%0d host_rdata", i),  32'(host_rdata),  32'(vt[i].hrd));
      chk($sformatf("v%0d host_wait", i),   32'(host_wait),   32'(vt[i].hwt));
    end

    // Contention: both hold requests, host forced through every fifth grant
    host_order = 10'b1000010000;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 16'h1000;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 16'h2000;
    for (int g = 0; g < 10; g++) begin
      wait_gnt($sformatf("cont g%0d", g), got);
      if (got) begin
        chk($sformatf("cont g%0d winner", g), 32'({cpu_gnt, host_gnt}),
            host_order[g] ? 32'd1 : 32'd2);
        chk($sformatf("cont g%0d host_wait", g), 32'(host_wait),
            host_order[g] ? 32'd0 : 32'((g % 5) + 1));
        chk($sformatf("cont g%0d ram_addr", g), 32'(ram_addr),
            host_order[g] ? 32'h40 : 32'h30);
      end
    end
    idle_inputs();
    tick();
    tick();
    chk("cont idle host_wait", 32'(host_wait), 32'd0);

    // Host drops its request while host_wait is 2
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h31; cpu_wdata = 16'h3000;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h41; host_wdata = 16'h4000;
    for (int g = 0; g < 2; g++) begin
      wait_gnt($sformatf("drop g%0d", g), got);
      if (got) begin
        chk($sformatf("drop g%0d cpu_gnt", g), 32'(cpu_gnt), 32'd1);
        chk($sformatf("drop g%0d host_wait", g), 32'(host_wait), 32'(g + 1));
      end
    end
    host_req = 1'b0;
    tick();
    chk("drop hold host_wait", 32'(host_wait), 32'd2);
    tick();
    chk("drop sample cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("drop sample host_wait", 32'(host_wait), 32'd0);
    idle_inputs();
    tick();
    tick();

    // Reset during WAIT_RD drops the read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h14;
    tick();
    chk("rst_rd cpu_gnt", 32'(cpu_gnt), 32'd1);
    cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_rd ram_en", 32'(ram_en), 32'd0);
    chk("rst_rd cpu_rdata", 32'(cpu_rdata), 32'd0);
    for (int c = 0; c < 4; c++) begin
      if (c == 2) reset = 1'b1;
      tick();
      chk($sformatf("rst_rd no_rvalid c%0d", c), 32'(cpu_rvalid), 32'd0);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h14;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 1) begin
        chk("rst_rd2 cpu_gnt", 32'(cpu_gnt), 32'd1);
        cpu_req = 1'b0;
      end
      if (cpu_rvalid) begin
        lat = n;
        break;
      end
    end
    chk("rst_rd2 latency", 32'(lat), 32'd3);
    chk("rst_rd2 cpu_rdata", 32'(cpu_rdata), 32'h0001);
    chk("rst_rd2 host_rdata", 32'(host_rdata), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
